// File: rtl/z88_mem_pkg.sv
// ============================================================================
// Module  : z88_mem_pkg
// Purpose : Shared types and constants for the slot-0 memory scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package z88_mem_pkg;

  // Scheduler access phases
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    SAMPLE = 2'd3
  } sched_state_t;

  // Which requester owns the current access
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LCD = 1'b1
  } owner_t;

  localparam logic [2:0] SLOT_ROM = 3'b000;
  localparam logic [2:0] SLOT_RAM = 3'b001;
  localparam logic [1:0] BE_LO    = 2'b10;
  localparam logic [1:0] BE_HI    = 2'b01;

  // Pick the byte lane enabled by an active-low byte-enable pair
  function automatic logic [7:0] lane_sel(input logic [1:0] be_n, input logic [15:0] d);
    return be_n[0] ? d[15:8] : d[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/z88_mem_sched_if.sv
// ============================================================================
// Module  : z88_mem_sched_if
// Purpose : Requester handshakes and external memory pins of the scheduler.
//           slave  = scheduler side, master = requesters/memory side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface z88_mem_sched_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [21:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        lcd_req;
  logic [21:0] lcd_addr;
  logic        lcd_ack;
  logic [7:0]  lcd_rdata;
  logic        rom_ce_n;
  logic        ram_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic [1:0]  mem_be_n;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] rom_rdata;
  logic [15:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, lcd_req, lcd_addr, rom_rdata, ram_rdata,
    output cpu_ack, cpu_rdata, lcd_ack, lcd_rdata,
    output rom_ce_n, ram_ce_n, mem_oe_n, mem_we_n, mem_be_n, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, lcd_req, lcd_addr, rom_rdata, ram_rdata,
    input  cpu_ack, cpu_rdata, lcd_ack, lcd_rdata,
    input  rom_ce_n, ram_ce_n, mem_oe_n, mem_we_n, mem_be_n, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/z88_sched_rr2.sv
// ============================================================================
// Module  : z88_sched_rr2
// Purpose : Two-way round-robin grant; when both request, the one not
//           granted last wins. Priority starts with the CPU after reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module z88_sched_rr2
  import z88_mem_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic req_cpu_i,
  input  wire logic req_lcd_i,
  input  wire logic grant_en_i,
  output logic      gnt_valid_o,
  output owner_t    gnt_owner_o
);

  owner_t prio_q;

  // Combinational grant: sole requester wins, ties go to the priority holder
  always_comb begin
    gnt_valid_o = req_cpu_i | req_lcd_i;
    gnt_owner_o = OWN_CPU;
    if (req_cpu_i && req_lcd_i) gnt_owner_o = prio_q;
    else if (req_lcd_i)         gnt_owner_o = OWN_LCD;
  end

  // Priority moves to the side that was not just granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            prio_q <= OWN_CPU;
    else if (grant_en_i && gnt_valid_o) prio_q <= (gnt_owner_o == OWN_CPU) ? OWN_LCD : OWN_CPU;
  end

endmodule

`default_nettype wire

// File: rtl/z88_mem_sched.sv
// ============================================================================
// Module  : z88_mem_sched
// Purpose : Shares the slot-0 16-bit ROM/RAM port between CPU and LCD.
//           IDLE -> SETUP -> STROBE(1+WAIT_STATES) -> SAMPLE -> IDLE, all
//           pin outputs registered. Optional macro Z88_SCHED_STATS_EN adds
//           cpu_wait_max/lcd_wait_max request-to-ack latency maxima.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module z88_mem_sched
  import z88_mem_pkg::*;
#(
  parameter logic [18:0] RAM_ADDR_MASK = 19'h07FFF,
  parameter int          WAIT_STATES   = 0,
  parameter bit          ROM_BYTE_WIDE = 1'b0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  z88_mem_sched_if.slave  bus
`ifdef Z88_SCHED_STATS_EN
  ,
  output logic [7:0]      cpu_wait_max,
  output logic [7:0]      lcd_wait_max
`endif
);

  localparam logic [1:0] WS_LAST = 2'(WAIT_STATES);

  sched_state_t state_q;
  owner_t       owner_q;
  owner_t       gnt_owner;
  logic         gnt_valid;
  logic         we_q, is_rom_q, is_ram_q;
  logic [1:0]   ws_cnt_q;
  logic         rom_ce_n_q, ram_ce_n_q, oe_n_q, we_n_q;
  logic [1:0]   be_n_q;
  logic [18:0]  mem_addr_q;
  logic [15:0]  mem_wdata_q;
  logic         cpu_ack_q, lcd_ack_q;
  logic [7:0]   cpu_rdata_q, lcd_rdata_q;

  logic [21:0]  w_sel_addr;
  logic         w_sel_we, w_is_rom, w_is_ram, w_rom8;
  logic [18:0]  w_byte_addr;
  logic [7:0]   w_lane;

  z88_sched_rr2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_cpu_i   (bus.cpu_req),
    .req_lcd_i   (bus.lcd_req),
    .grant_en_i  (state_q == IDLE),
    .gnt_valid_o (gnt_valid),
    .gnt_owner_o (gnt_owner)
  );

  // Decode the address of the requester about to be granted so the pins are
  // already valid in the SETUP cycle
  always_comb begin
    w_sel_addr  = (gnt_owner == OWN_CPU) ? bus.cpu_addr : bus.lcd_addr;
    w_sel_we    = (gnt_owner == OWN_CPU) ? bus.cpu_we : 1'b0;
    w_is_rom    = (w_sel_addr[21:19] == SLOT_ROM);
    w_is_ram    = (w_sel_addr[21:19] == SLOT_RAM);
    w_rom8      = w_is_rom && ROM_BYTE_WIDE;
    w_byte_addr = w_is_ram ? (w_sel_addr[18:0] & RAM_ADDR_MASK) : w_sel_addr[18:0];
    w_lane      = 8'h00;
    if (is_rom_q)      w_lane = lane_sel(be_n_q, bus.rom_rdata);
    else if (is_ram_q) w_lane = lane_sel(be_n_q, bus.ram_rdata);
  end

  // Access sequencer with registered strobes, acks and read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      is_rom_q    <= 1'b0;
      is_ram_q    <= 1'b0;
      ws_cnt_q    <= 2'd0;
      rom_ce_n_q  <= 1'b1;
      ram_ce_n_q  <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 2'b11;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      lcd_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      lcd_rdata_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      lcd_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            owner_q     <= gnt_owner;
            we_q        <= w_sel_we;
            is_rom_q    <= w_is_rom;
            is_ram_q    <= w_is_ram;
            rom_ce_n_q  <= ~w_is_rom;
            ram_ce_n_q  <= ~w_is_ram;
            mem_addr_q  <= w_rom8 ? w_byte_addr : {1'b0, w_byte_addr[18:1]};
            be_n_q      <= (w_rom8 || !w_sel_addr[0]) ? BE_LO : BE_HI;
            mem_wdata_q <= {bus.cpu_wdata, bus.cpu_wdata};
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          ws_cnt_q <= 2'd0;
          // ROM writes and unmapped accesses get no strobe at all
          oe_n_q   <= ~(!we_q && (is_rom_q || is_ram_q));
          we_n_q   <= ~(we_q && is_ram_q);
          state_q  <= STROBE;
        end
        STROBE: begin
          if (ws_cnt_q == WS_LAST) begin
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            state_q <= SAMPLE;
          end else begin
            ws_cnt_q <= ws_cnt_q + 2'd1;
          end
        end
        SAMPLE: begin
          if (owner_q == OWN_CPU) begin
            cpu_ack_q <= 1'b1;
            if (!we_q) cpu_rdata_q <= w_lane;
          end else begin
            lcd_ack_q   <= 1'b1;
            lcd_rdata_q <= w_lane;
          end
          rom_ce_n_q <= 1'b1;
          ram_ce_n_q <= 1'b1;
          be_n_q     <= 2'b11;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rom_ce_n  = rom_ce_n_q;
  assign bus.ram_ce_n  = ram_ce_n_q;
  assign bus.mem_oe_n  = oe_n_q;
  assign bus.mem_we_n  = we_n_q;
  assign bus.mem_be_n  = be_n_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.lcd_ack   = lcd_ack_q;
  assign bus.lcd_rdata = lcd_rdata_q;

`ifdef Z88_SCHED_STATS_EN
  logic       cpu_busy_q, lcd_busy_q;
  logic [7:0] cpu_cnt_q, lcd_cnt_q, cpu_max_q, lcd_max_q;

  // CPU wait tracker: count clocks from request start to ack, keep maximum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_busy_q <= 1'b0;
      cpu_cnt_q  <= '0;
      cpu_max_q  <= '0;
    end else if (cpu_busy_q && cpu_ack_q) begin
      cpu_busy_q <= 1'b0;
      if (cpu_cnt_q > cpu_max_q) cpu_max_q <= cpu_cnt_q;
    end else if (cpu_busy_q) begin
      if (cpu_cnt_q != 8'hFF) cpu_cnt_q <= cpu_cnt_q + 8'd1;
    end else if (bus.cpu_req) begin
      cpu_busy_q <= 1'b1;
      cpu_cnt_q  <= 8'd1;
    end
  end

  // LCD wait tracker: same scheme as the CPU one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_busy_q <= 1'b0;
      lcd_cnt_q  <= '0;
      lcd_max_q  <= '0;
    end else if (lcd_busy_q && lcd_ack_q) begin
      lcd_busy_q <= 1'b0;
      if (lcd_cnt_q > lcd_max_q) lcd_max_q <= lcd_cnt_q;
    end else if (lcd_busy_q) begin
      if (lcd_cnt_q != 8'hFF) lcd_cnt_q <= lcd_cnt_q + 8'd1;
    end else if (bus.lcd_req) begin
      lcd_busy_q <= 1'b1;
      lcd_cnt_q  <= 8'd1;
    end
  end

  assign cpu_wait_max = cpu_max_q;
  assign lcd_wait_max = lcd_max_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_z88_mem_sched.sv
// ============================================================================
// Module  : tb_z88_mem_sched
// Purpose : Directed self-checking bench for z88_mem_sched (WAIT_STATES=0
//           and WAIT_STATES=2 instances).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_z88_mem_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  z88_mem_sched_if b0 ();
  z88_mem_sched_if b1 ();

`ifdef Z88_SCHED_STATS_EN
  logic [7:0] cwm0, lwm0, cwm1, lwm1;
`endif

  z88_mem_sched #(.WAIT_STATES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
`ifdef Z88_SCHED_STATS_EN
    , .cpu_wait_max (cwm0), .lcd_wait_max (lwm0)
`endif
  );

  z88_mem_sched #(.WAIT_STATES(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
`ifdef Z88_SCHED_STATS_EN
    , .cpu_wait_max (cwm1), .lcd_wait_max (lwm1)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Follow one access on dut0 until an ack (bounded); ack_tick stays 0 on timeout
  task automatic mon0(output int ram_lo, output int rom_lo, output int oe_lo, output int we_lo,
                      output int ack_tick, output logic ack_cpu, output logic [1:0] be,
                      output logic [18:0] addr, output logic [15:0] wd);
    ram_lo = 0; rom_lo = 0; oe_lo = 0; we_lo = 0; ack_tick = 0; ack_cpu = 1'b0;
    be = 2'b11; addr = '0; wd = '0;
    for (int i = 1; i <= 20 && ack_tick == 0; i++) begin
      tick();
      if (!b0.ram_ce_n) ram_lo++;
      if (!b0.rom_ce_n) rom_lo++;
      if (!b0.mem_oe_n) oe_lo++;
      if (!b0.mem_we_n) we_lo++;
      if (i == 1) begin
        be = b0.mem_be_n; addr = b0.mem_addr; wd = b0.mem_wdata;
      end
      if (b0.cpu_ack || b0.lcd_ack) begin
        ack_tick = i;
        ack_cpu  = b0.cpu_ack;
      end
    end
  endtask

  initial begin
    int ram_lo, rom_lo, oe_lo, we_lo, ack_tick;
    logic ack_cpu;
    logic [1:0] be;
    logic [18:0] addr;
    logic [15:0] wd;

    b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = '0; b0.cpu_wdata = '0;
    b0.lcd_req = 0; b0.lcd_addr = '0; b0.rom_rdata = 16'hC3A7; b0.ram_rdata = 16'hBEEF;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.lcd_req = 0; b1.lcd_addr = '0; b1.rom_rdata = 16'hA55A; b1.ram_rdata = 16'h0000;

    // Reset state
    tick(); tick();
    check("rst_ce", 32'({b0.rom_ce_n, b0.ram_ce_n, b0.mem_oe_n, b0.mem_we_n}), 'hF);
    check("rst_be", 32'(b0.mem_be_n), 'h3);
    check("rst_addr_wdata", 32'({b0.mem_addr, b0.mem_wdata}), 'h0);
    check("rst_ack_rdata", 32'({b0.cpu_ack, b0.lcd_ack, b0.cpu_rdata, b0.lcd_rdata}), 'h0);
    rst = 0;
    tick();

    // 1: CPU read RAM 0x080003 -> high lane of word 1
    b0.cpu_addr = 22'h080003; b0.cpu_we = 0; b0.cpu_req = 1;
    mon0(ram_lo, rom_lo, oe_lo, we_lo, ack_tick, ack_cpu, be, addr, wd);
    check("t1_ram_ce_cycles", 32'(ram_lo), 3);
    check("t1_rom_ce_cycles", 32'(rom_lo), 0);
    check("t1_oe_cycles", 32'(oe_lo), 1);
    check("t1_be", 32'(be), 'h1);
    check("t1_addr", 32'(addr), 'h1);
    check("t1_ack_latency", 32'(ack_tick - 1), 3);
    check("t1_ack_owner", 32'(ack_cpu), 1);
    check("t1_rdata", 32'(b0.cpu_rdata), 'hBE);
    b0.cpu_req = 0;
    tick();
    check("t1_ack_pulse", 32'(b0.cpu_ack), 0);
    check("t1_rdata_hold", 32'(b0.cpu_rdata), 'hBE);

    // 2: CPU write 0x5A to RAM 0x080000
    b0.cpu_addr = 22'h080000; b0.cpu_we = 1; b0.cpu_wdata = 8'h5A; b0.cpu_req = 1;
    mon0(ram_lo, rom_lo, oe_lo, we_lo, ack_tick, ack_cpu, be, addr, wd);
    check("t2_we_cycles", 32'(we_lo), 1);
    check("t2_oe_cycles", 32'(oe_lo), 0);
    check("t2_be", 32'(be), 'h2);
    check("t2_wdata", 32'(wd), 'h5A5A);
    check("t2_addr", 32'(addr), 'h0);
    check("t2_ack", 32'({ack_cpu, 8'(ack_tick)}), 'h104);
    b0.cpu_req = 0; b0.cpu_we = 0;
    tick();

    // LCD read ROM 0x000005 -> high lane of ROM word 2
    b0.lcd_addr = 22'h000005; b0.lcd_req = 1;
    mon0(ram_lo, rom_lo, oe_lo, we_lo, ack_tick, ack_cpu, be, addr, wd);
    check("lr_rom_ce_cycles", 32'(rom_lo), 3);
    check("lr_addr_be", 32'({addr, be}), 32'({19'd2, 2'b01}));
    check("lr_ack", 32'({ack_cpu, 8'(ack_tick)}), 'h004);
    check("lr_rdata", 32'(b0.lcd_rdata), 'hC3);
    b0.lcd_req = 0;
    tick();

    // 3: both held for four accesses -> CPU, LCD, CPU, LCD in 4-clock steps
    b0.cpu_addr = 22'h080000; b0.cpu_we = 0; b0.lcd_addr = 22'h000002;
    b0.cpu_req = 1; b0.lcd_req = 1;
    for (int k = 0; k < 4; k++) begin
      mon0(ram_lo, rom_lo, oe_lo, we_lo, ack_tick, ack_cpu, be, addr, wd);
      check($sformatf("t3_step%0d", k), 32'(ack_tick), 4);
      check($sformatf("t3_owner%0d", k), 32'(ack_cpu), (k % 2 == 0) ? 1 : 0);
      if (k == 3) begin
        b0.cpu_req = 0; b0.lcd_req = 0;
      end
    end
    check("t3_cpu_rdata", 32'(b0.cpu_rdata), 'hEF);
    check("t3_lcd_rdata", 32'(b0.lcd_rdata), 'hA7);
    tick();

    // 4: LCD read unmapped 0x200000 -> no CE, rdata 00
    b0.lcd_addr = 22'h200000; b0.lcd_req = 1;
    mon0(ram_lo, rom_lo, oe_lo, we_lo, ack_tick, ack_cpu, be, addr, wd);
    check("t4_no_ce", 32'(ram_lo + rom_lo + oe_lo + we_lo), 0);
    check("t4_ack", 32'({ack_cpu, 8'(ack_tick)}), 'h004);
    check("t4_rdata", 32'(b0.lcd_rdata), 'h00);
    b0.lcd_req = 0;
    tick();

    // 5: reset in the STROBE phase of a RAM write
    b0.cpu_addr = 22'h080010; b0.cpu_we = 1; b0.cpu_wdata = 8'h33; b0.cpu_req = 1;
    tick();
    check("t5_setup_ce", 32'(b0.ram_ce_n), 0);
    tick();
    check("t5_strobe_we", 32'(b0.mem_we_n), 0);
    #2 rst = 1;
    #1;
    check("t5_async_release", 32'({b0.mem_we_n, b0.ram_ce_n, b0.cpu_ack}), 'h6);
    b0.cpu_we = 0; b0.cpu_addr = 22'h080003; b0.lcd_addr = 22'h000005; b0.lcd_req = 1;
    tick();
    check("t5_no_ack_in_reset", 32'({b0.cpu_ack, b0.lcd_ack}), 0);
    rst = 0;
    mon0(ram_lo, rom_lo, oe_lo, we_lo, ack_tick, ack_cpu, be, addr, wd);
    check("t5_first_grant_cpu", 32'({ack_cpu, 8'(ack_tick)}), 'h104);
    check("t5_rdata", 32'(b0.cpu_rdata), 'hBE);
    b0.cpu_req = 0; b0.lcd_req = 0;
    tick();

    // 6: WAIT_STATES=2 ROM read 0x000000 -> CE low 5, ack 5 after grant, low lane
    b1.cpu_addr = 22'h000000; b1.cpu_we = 0; b1.cpu_req = 1;
    rom_lo = 0; oe_lo = 0; ack_tick = 0;
    for (int i = 1; i <= 20 && ack_tick == 0; i++) begin
      tick();
      if (!b1.rom_ce_n) rom_lo++;
      if (!b1.mem_oe_n) oe_lo++;
      if (b1.cpu_ack) ack_tick = i;
    end
    b1.cpu_req = 0;
    check("t6_rom_ce_cycles", 32'(rom_lo), 5);
    check("t6_oe_cycles", 32'(oe_lo), 3);
    check("t6_ack_latency", 32'(ack_tick - 1), 5);
    check("t6_rdata", 32'(b1.cpu_rdata), 'h5A);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
